// File: rtl/btn_onehot_source.sv
// btn_onehot_source: synchronises and debounces button lines, emits latched presses as one-hot words lowest index first
module btn_onehot_source #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] v,
    output logic [WIDTH-1:0] pending
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] s1, s2, db, db_nxt, rise, lowest;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic             load;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            db_nxt[i]  = (s2[i] != db[i] && cnt[i] == CNT_MAX) ? s2[i] : db[i];
            cnt_nxt[i] = (s2[i] == db[i] || cnt[i] == CNT_MAX) ? '0 : cnt[i] + CNT_W'(1);
        end
    end

    assign rise   = db_nxt & ~db;
    // two's-complement trick isolates the lowest set bit (zero when nothing pending)
    assign lowest = pending & (~pending + WIDTH'(1));
    assign load   = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            s2        <= '0;
            db        <= '0;
            cnt       <= '{default: '0};
            pending   <= '0;
            out_valid <= 1'b0;
            v         <= '0;
        end else begin
            s1      <= btn;
            s2      <= s1;
            db      <= db_nxt;
            cnt     <= cnt_nxt;
            pending <= (load ? pending & ~lowest : pending) | rise;
            if (load) begin
                v         <= lowest;
                out_valid <= |pending;
            end
        end
    end
endmodule

// File: tb/tb_btn_onehot_source.sv
// tb_btn_onehot_source: random and directed stimulus checked every cycle against a window-based behavioural model
module tb_btn_onehot_source;
    localparam int W  = 8;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] btn;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] v;
    logic [W-1:0] pending;

    btn_onehot_source #(.WIDTH(W), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .out_ready(out_ready),
        .out_valid(out_valid), .v(v), .pending(pending)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model: btn is delayed two samples; a level is accepted once the last DB
    // samples the debouncer saw all disagree with the currently accepted level
    logic [W-1:0] m_s1, m_s2, m_db, m_pend, m_v;
    logic         m_valid;
    logic [W-1:0] hist [DB];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_pend = '0; m_v = '0; m_valid = 1'b0;
        for (int k = 0; k < DB; k++) hist[k] = '0;
    endtask

    task automatic model_step();
        logic [W-1:0] rise;
        logic         all_diff;
        int           lo;
        rise = '0;
        for (int k = DB - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = m_s2;
        for (int i = 0; i < W; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DB; k++) if (hist[k][i] == m_db[i]) all_diff = 1'b0;
            if (all_diff) begin
                m_db[i] = ~m_db[i];
                if (m_db[i]) rise[i] = 1'b1;
            end
        end
        if (!m_valid || out_ready) begin
            lo = -1;
            for (int i = W - 1; i >= 0; i--) if (m_pend[i]) lo = i;
            m_valid = (lo >= 0);
            m_v = '0;
            if (lo >= 0) begin
                m_v[lo] = 1'b1;
                m_pend[lo] = 1'b0;
            end
        end
        m_pend = m_pend | rise;
        m_s2 = m_s1;
        m_s1 = btn;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("out_valid", {7'b0, out_valid}, {7'b0, m_valid});
        chk("v", v, m_v);
        chk("pending", pending, m_pend);
    endtask

    // called at a negedge: drive inputs, advance model over the next posedge, compare at the following negedge
    task automatic cyc(input logic [W-1:0] b, input logic r);
        btn = b;
        out_ready = r;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        rst_n = 1'b0; btn = '0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_valid", {7'b0, out_valid}, 8'h00);
        chk("reset_v", v, 8'h00);
        chk("reset_pending", pending, 8'h00);
        rst_n = 1'b1;
        repeat (4) cyc(8'h00, 1'b1);

        // each button in turn: pending at edge 6, out_valid for one cycle at edge 7
        for (int i = 0; i < W; i++) begin
            for (int c = 1; c <= 20; c++) begin
                cyc(W'(1) << i, 1'b1);
                if (c == 6) chk("t1_pending", pending, W'(1) << i);
                if (c == 7) begin
                    chk("t1_valid", {7'b0, out_valid}, 8'h01);
                    chk("t1_v", v, W'(1) << i);
                end
                if (c == 8) chk("t1_valid_drop", {7'b0, out_valid}, 8'h00);
            end
            repeat (20) cyc(8'h00, 1'b1);
        end

        // 3-cycle glitch is ignored, 5-cycle pulse makes exactly one event
        repeat (3) cyc(8'h08, 1'b1);
        repeat (10) begin
            cyc(8'h00, 1'b1);
            chk("t2_glitch_pending", pending, 8'h00);
            chk("t2_glitch_valid", {7'b0, out_valid}, 8'h00);
        end
        for (int c = 1; c <= 5; c++) cyc(8'h08, 1'b1);
        cyc(8'h00, 1'b1);
        chk("t2_pending", pending, 8'h08);
        cyc(8'h00, 1'b1);
        chk("t2_v", v, 8'h08);
        repeat (12) cyc(8'h00, 1'b1);

        // simultaneous presses drain in ascending order
        for (int c = 1; c <= 10; c++) begin
            cyc(8'hA4, 1'b1);
            if (c == 6) chk("t3_pending", pending, 8'hA4);
            if (c == 7) chk("t3_v0", v, 8'h04);
            if (c == 8) chk("t3_v1", v, 8'h20);
            if (c == 9) chk("t3_v2", v, 8'h80);
            if (c == 10) chk("t3_idle", {7'b0, out_valid}, 8'h00);
        end
        repeat (12) cyc(8'h00, 1'b1);

        // backpressure holds v stable
        repeat (7) cyc(8'h42, 1'b0);
        repeat (10) begin
            cyc(8'h42, 1'b0);
            chk("t4_hold_v", v, 8'h02);
            chk("t4_hold_pending", pending, 8'h40);
        end
        cyc(8'h00, 1'b1);
        chk("t4_v_next", v, 8'h40);
        cyc(8'h00, 1'b1);
        chk("t4_idle", {7'b0, out_valid}, 8'h00);
        repeat (12) cyc(8'h00, 1'b1);

        // repeat presses of channel held in v merge into one pending bit
        repeat (7) cyc(8'h20, 1'b0);
        chk("t5_v", v, 8'h20);
        repeat (8) cyc(8'h00, 1'b0);
        repeat (8) cyc(8'h20, 1'b0);
        repeat (8) cyc(8'h00, 1'b0);
        chk("t5_pending", pending, 8'h20);
        cyc(8'h00, 1'b1);
        chk("t5_v_again", v, 8'h20);
        chk("t5_pending_clear", pending, 8'h00);
        cyc(8'h00, 1'b1);
        chk("t5_idle", {7'b0, out_valid}, 8'h00);
        repeat (8) cyc(8'h00, 1'b1);

        // random stimulus
        for (int n = 0; n < 300; n++) begin
            logic [W-1:0] b;
            b = W'($urandom);
            repeat ($urandom_range(1, 8)) cyc(b, ($urandom % 4) != 0);
        end
        repeat (20) cyc(8'h00, 1'b1);

        // asynchronous reset discards queued presses
        repeat (6) cyc(8'hF0, 1'b0);
        chk("t6_pre_pending", pending, 8'hF0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_valid", {7'b0, out_valid}, 8'h00);
        chk("t6_v", v, 8'h00);
        chk("t6_pending", pending, 8'h00);
        btn = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) cyc(8'h00, 1'b1);
        chk("t6_quiet", {7'b0, out_valid}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
